// File: rtl/color_addr_gen.sv
// Strided two-level address generator: issues base + f*feat_stride + l*line_stride over a job.
// Optional stall counter output enabled by defining COLOR_ADDR_GEN_STALL_CNT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start_i; config inputs latched on acceptance
// ST_RUN  | presenting addresses on the valid/ready stream
// ST_DONE | one-cycle done_o pulse, then back to idle
module color_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] line_stride_i,
  input  logic [CNT_W-1:0]  line_length_i,
  input  logic [ADDR_W-1:0] feat_stride_i,
  input  logic [CNT_W-1:0]  feat_length_i,
  input  logic [CNT_W-1:0]  trans_size_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef COLOR_ADDR_GEN_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_line_stride;
  logic [ADDR_W-1:0] r_feat_stride;
  logic [CNT_W-1:0]  r_line_last;
  logic [CNT_W-1:0]  r_feat_last;
  logic [CNT_W-1:0]  r_remain;
  logic [CNT_W-1:0]  r_l;
  logic [CNT_W-1:0]  r_f;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_line_addr;

  logic w_start;
  logic w_xfer;
  logic w_line_end;
  logic w_feat_end;
  logic [ADDR_W-1:0] w_next_line_addr;

  assign w_start          = (r_state == ST_IDLE) && start_i;
  assign w_xfer           = (r_state == ST_RUN) && addr_ready_i;
  assign w_line_end       = (r_l == r_line_last);
  assign w_feat_end       = (r_f == r_feat_last);
  assign w_next_line_addr = r_line_addr + r_feat_stride;

  assign addr_o       = r_addr;
  assign addr_valid_o = (r_state == ST_RUN);
  assign busy_o       = (r_state != ST_IDLE);
  assign done_o       = (r_state == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_next = (trans_size_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_xfer && (r_remain == CNT_ONE)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Lengths of zero behave as one, so the stored "last index" is simply 0 for them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_base        <= '0;
      r_line_stride <= '0;
      r_feat_stride <= '0;
      r_line_last   <= '0;
      r_feat_last   <= '0;
      r_remain      <= '0;
      r_l           <= '0;
      r_f           <= '0;
      r_addr        <= '0;
      r_line_addr   <= '0;
    end else if (w_start) begin
      r_base        <= base_addr_i;
      r_line_stride <= line_stride_i;
      r_feat_stride <= feat_stride_i;
      r_line_last   <= (line_length_i == '0) ? '0 : line_length_i - CNT_ONE;
      r_feat_last   <= (feat_length_i == '0) ? '0 : feat_length_i - CNT_ONE;
      r_remain      <= trans_size_i;
      r_l           <= '0;
      r_f           <= '0;
      r_addr        <= base_addr_i;
      r_line_addr   <= base_addr_i;
    end else if (w_xfer) begin
      r_remain <= r_remain - CNT_ONE;
      if (!w_line_end) begin
        r_l    <= r_l + CNT_ONE;
        r_addr <= r_addr + r_line_stride;
      end else begin
        r_l <= '0;
        if (w_feat_end) begin
          r_f         <= '0;
          r_addr      <= r_base;
          r_line_addr <= r_base;
        end else begin
          r_f         <= r_f + CNT_ONE;
          r_addr      <= w_next_line_addr;
          r_line_addr <= w_next_line_addr;
        end
      end
    end
  end

`ifdef COLOR_ADDR_GEN_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   r_stall_cnt <= '0;
    else if (w_start)                              r_stall_cnt <= '0;
    else if ((r_state == ST_RUN) && !addr_ready_i && (r_stall_cnt != '1))
                                                   r_stall_cnt <= r_stall_cnt + CNT_ONE;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
